// File: rtl/grid_pkg.sv
// grid_pkg: colours, FSM states, the 3x5 digit font and the 2^value label table
// shared by grid_renderer and tile_glyph_rom.
package grid_pkg;

    localparam logic [2:0] COL_TILE = 3'b100;
    localparam logic [2:0] COL_TEXT = 3'b111;
    localparam logic [2:0] COL_ERR  = 3'b110;

    localparam int MAX_LABEL_VALUE = 12;
    localparam int FONT_W          = 3;
    localparam int FONT_H          = 5;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } state_t;

    // Glyph rows top to bottom, three bits per row, leftmost pixel in the MSB of each row.
    localparam logic [14:0] FONT_0 = 15'b111_101_101_101_111;
    localparam logic [14:0] FONT_1 = 15'b010_110_010_010_111;
    localparam logic [14:0] FONT_2 = 15'b111_001_111_100_111;
    localparam logic [14:0] FONT_3 = 15'b111_001_111_001_111;
    localparam logic [14:0] FONT_4 = 15'b101_101_111_001_001;
    localparam logic [14:0] FONT_5 = 15'b111_100_111_001_111;
    localparam logic [14:0] FONT_6 = 15'b111_100_111_101_111;
    localparam logic [14:0] FONT_7 = 15'b111_001_001_001_001;
    localparam logic [14:0] FONT_8 = 15'b111_101_111_101_111;
    localparam logic [14:0] FONT_9 = 15'b111_101_111_001_111;

    function automatic logic [14:0] glyphBits(input logic [3:0] digit);
        logic [14:0] bits;
        case (digit)
            4'd0:    bits = FONT_0;
            4'd1:    bits = FONT_1;
            4'd2:    bits = FONT_2;
            4'd3:    bits = FONT_3;
            4'd4:    bits = FONT_4;
            4'd5:    bits = FONT_5;
            4'd6:    bits = FONT_6;
            4'd7:    bits = FONT_7;
            4'd8:    bits = FONT_8;
            4'd9:    bits = FONT_9;
            default: bits = 15'b0;
        endcase
        return bits;
    endfunction

    function automatic int labelLen(input int value);
        int len;
        case (value)
            1, 2, 3:    len = 1;
            4, 5, 6:    len = 2;
            7, 8, 9:    len = 3;
            10, 11, 12: len = 4;
            default:    len = 0;
        endcase
        return len;
    endfunction

    // Decimal text of 2^value as BCD, least significant digit in the low nibble.
    function automatic logic [15:0] labelBcd(input int value);
        logic [15:0] bcd;
        case (value)
            1:       bcd = 16'h0002;
            2:       bcd = 16'h0004;
            3:       bcd = 16'h0008;
            4:       bcd = 16'h0016;
            5:       bcd = 16'h0032;
            6:       bcd = 16'h0064;
            7:       bcd = 16'h0128;
            8:       bcd = 16'h0256;
            9:       bcd = 16'h0512;
            10:      bcd = 16'h1024;
            11:      bcd = 16'h2048;
            12:      bcd = 16'h4096;
            default: bcd = 16'h0000;
        endcase
        return bcd;
    endfunction

endpackage

// File: rtl/grid_renderer_glyph.sv
// tile_glyph_rom: decides whether a pixel of a tile is part of its centred 2^value label
// (lit) or belongs to an out-of-range value (err). Purely combinational.
module tile_glyph_rom
    import grid_pkg::*;
#(
    parameter int TILE_PX = 15,
    parameter int VAL_W   = 4,
    parameter int PW      = $clog2(TILE_PX)
) (
    input  logic [VAL_W-1:0] value,
    input  logic [PW-1:0]    px,
    input  logic [PW-1:0]    py,
    output logic             lit,
    output logic             err
);

    int          v;
    int          digits;
    int          boxW;
    int          relX;
    int          relY;
    int          slot;
    logic [15:0] bcd;
    logic [3:0]  digit;
    logic [14:0] bits;

    // Digits sit in 4-pixel slots (3 glyph columns plus a 1-pixel gap); the box is
    // centred with integer division so odd leftovers go to the right/bottom.
    always_comb begin
        v      = int'(value);
        digits = labelLen(v);
        bcd    = labelBcd(v);
        boxW   = 4 * digits - 1;
        relX   = int'(px) - (TILE_PX - boxW) / 2;
        relY   = int'(py) - (TILE_PX - FONT_H) / 2;
        slot   = 0;
        digit  = 4'd0;
        bits   = 15'b0;
        lit    = 1'b0;
        err    = (v > MAX_LABEL_VALUE);
        if (v >= 1 && v <= MAX_LABEL_VALUE &&
            relX >= 0 && relX < boxW && relY >= 0 && relY < FONT_H &&
            (relX % 4) != FONT_W) begin
            slot  = relX / 4;
            digit = bcd[(digits - 1 - slot) * 4 +: 4];
            bits  = glyphBits(digit);
            lit   = bits[14 - (relY * FONT_W + (relX % 4))];
        end
    end

endmodule

// File: rtl/grid_renderer.sv
// grid_renderer: walks an N x N board and streams one pixel per cycle to the VGA plotter.
// Optional DIRTY_REDRAW_EN: only tiles that changed since the previous frame are drawn.
module grid_renderer
    import grid_pkg::*;
#(
    parameter int GRID_N   = 4,
    parameter int TILE_PX  = 15,
    parameter int GAP_PX   = 2,
    parameter int ORIGIN_X = 57,
    parameter int ORIGIN_Y = 27,
    parameter int VAL_W    = 4,
    parameter int COORD_W  = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [GRID_N*GRID_N*VAL_W-1:0]   values,
    output logic                             busy,
    output logic                             done,
    output logic                             plot,
    output logic [COORD_W-1:0]               x,
    output logic [COORD_W-1:0]               y,
    output logic [2:0]                       colour
);

    localparam int NT    = GRID_N * GRID_N;
    localparam int TW    = $clog2(NT + 1);
    localparam int PW    = $clog2(TILE_PX);
    localparam int VW    = NT * VAL_W;
    localparam int PITCH = TILE_PX + GAP_PX;

    state_t               state_q;
    logic [TW-1:0]        tile_q;
    logic [PW-1:0]        px_q;
    logic [PW-1:0]        py_q;
    logic [VW-1:0]        snapshot_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 plot_q;
    logic [COORD_W-1:0]   x_q;
    logic [COORD_W-1:0]   y_q;
    logic [2:0]           colour_q;

`ifdef DIRTY_REDRAW_EN
    logic [VW-1:0]        prev_q;
    logic                 prevValid_q;
    logic                 snapValid_q;
    logic [VW-1:0]        prevSrc;
    logic                 prevValidSrc;
`endif

    logic [VW-1:0]        snapSrc;
    logic [NT-1:0]        dirty;
    int                   issueTile;
    int                   tileSel;
    int                   tile_d;
    logic                 issueValid;
    logic [PW-1:0]        issuePx;
    logic [PW-1:0]        issuePy;
    logic [PW-1:0]        px_d;
    logic [PW-1:0]        py_d;
    logic [VAL_W-1:0]     issueVal;
    logic [COORD_W-1:0]   issueX;
    logic [COORD_W-1:0]   issueY;
    logic [2:0]           issueColour;
    logic                 glyphLit;
    logic                 glyphErr;

    // Lowest tile index >= from that needs drawing, or NT when none is left.
    function automatic int firstDirty(input logic [NT-1:0] mask, input int from);
        int res;
        res = NT;
        for (int i = NT - 1; i >= 0; i--) begin
            if (i >= from && mask[i]) begin
                res = i;
            end
        end
        return res;
    endfunction

    // In IDLE the pixel being prepared is the first one of the frame about to start, so it
    // reads the live values; during DRAW everything comes from the snapshot.
    always_comb begin
        snapSrc = (state_q == IDLE) ? values : snapshot_q;
        dirty   = '1;
`ifdef DIRTY_REDRAW_EN
        prevSrc      = (state_q == IDLE) ? snapshot_q : prev_q;
        prevValidSrc = (state_q == IDLE) ? snapValid_q : prevValid_q;
        for (int i = 0; i < NT; i++) begin
            dirty[i] = !prevValidSrc ||
                       (snapSrc[(NT-1-i)*VAL_W +: VAL_W] != prevSrc[(NT-1-i)*VAL_W +: VAL_W]);
        end
`endif
        if (state_q == IDLE) begin
            issueTile = firstDirty(dirty, 0);
            issuePx   = '0;
            issuePy   = '0;
        end else begin
            issueTile = int'(tile_q);
            issuePx   = px_q;
            issuePy   = py_q;
        end
        issueValid = (issueTile < NT);
        tileSel    = issueValid ? issueTile : 0;
        issueVal   = snapSrc[(NT-1-tileSel)*VAL_W +: VAL_W];
        issueX     = COORD_W'(ORIGIN_X + (tileSel % GRID_N) * PITCH + int'(issuePx));
        issueY     = COORD_W'(ORIGIN_Y + (tileSel / GRID_N) * PITCH + int'(issuePy));

        if (glyphErr) begin
            issueColour = COL_ERR;
        end else if (glyphLit) begin
            issueColour = COL_TEXT;
        end else begin
            issueColour = COL_TILE;
        end

        px_d   = issuePx + PW'(1);
        py_d   = issuePy;
        tile_d = issueTile;
        if (int'(issuePx) == TILE_PX - 1) begin
            px_d = '0;
            if (int'(issuePy) == TILE_PX - 1) begin
                py_d   = '0;
                tile_d = firstDirty(dirty, issueTile + 1);
            end else begin
                py_d = issuePy + PW'(1);
            end
        end
    end

    tile_glyph_rom #(
        .TILE_PX (TILE_PX),
        .VAL_W   (VAL_W),
        .PW      (PW)
    ) u_glyph (
        .value (issueVal),
        .px    (issuePx),
        .py    (issuePy),
        .lit   (glyphLit),
        .err   (glyphErr)
    );

    // The counters always point at the next pixel to emit; each DRAW cycle registers the
    // current one onto the outputs and advances, and running off the end finishes the frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            tile_q     <= '0;
            px_q       <= '0;
            py_q       <= '0;
            snapshot_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            plot_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
`ifdef DIRTY_REDRAW_EN
            prev_q      <= '0;
            prevValid_q <= 1'b0;
            snapValid_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            plot_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        snapshot_q <= values;
`ifdef DIRTY_REDRAW_EN
                        prev_q      <= snapshot_q;
                        prevValid_q <= snapValid_q;
                        snapValid_q <= 1'b1;
`endif
                        if (issueValid) begin
                            state_q  <= DRAW;
                            busy_q   <= 1'b1;
                            plot_q   <= 1'b1;
                            x_q      <= issueX;
                            y_q      <= issueY;
                            colour_q <= issueColour;
                            tile_q   <= TW'(tile_d);
                            px_q     <= px_d;
                            py_q     <= py_d;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DRAW: begin
                    if (issueValid) begin
                        plot_q   <= 1'b1;
                        x_q      <= issueX;
                        y_q      <= issueY;
                        colour_q <= issueColour;
                        tile_q   <= TW'(tile_d);
                        px_q     <= px_d;
                        py_q     <= py_d;
                    end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign plot   = plot_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;

endmodule

// File: tb/tb_grid_renderer.sv
// Directed bench for grid_renderer at default parameters; captures whole frames and
// compares pixels, handshake timing and abort behaviour against hand-computed values.
module tb_grid_renderer;

    localparam int NPIX = 3600;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [63:0] values = 64'h0;
    logic        busy;
    logic        done;
    logic        plot;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;

    int nChecks = 0;
    int nFails  = 0;

    logic [7:0] capX [NPIX];
    logic [7:0] capY [NPIX];
    logic [2:0] capC [NPIX];
    int plotCount;
    int doneCount;
    int doneCycle;
    int extra;
    bit gapSeen;
    bit busyLow;
    bit timedOut;

    always #5 clock = ~clock;

    grid_renderer dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .values (values),
        .busy   (busy),
        .done   (done),
        .plot   (plot),
        .x      (x),
        .y      (y),
        .colour (colour)
    );

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Starts one frame and records every plotted pixel until done; optionally changes
    // values and pulses start once changeAt pixels have been seen.
    task automatic runFrame(input logic [63:0] vals, input int changeAt, input logic [63:0] vals2);
        int cyc;
        bit lastPlot;
        bit finished;
        plotCount = 0;
        doneCount = 0;
        doneCycle = -1;
        gapSeen   = 1'b0;
        busyLow   = 1'b0;
        timedOut  = 1'b0;
        lastPlot  = 1'b0;
        finished  = 1'b0;
        cyc       = 0;
        @(negedge clock);
        values = vals;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        while (!finished && cyc < 5000) begin
            if (plot) begin
                if (plotCount < NPIX) begin
                    capX[plotCount] = x;
                    capY[plotCount] = y;
                    capC[plotCount] = colour;
                end
                if (plotCount > 0 && !lastPlot) gapSeen = 1'b1;
                if (!busy) busyLow = 1'b1;
                plotCount++;
            end
            if (done) begin
                doneCount++;
                doneCycle = cyc;
                finished  = 1'b1;
            end
            lastPlot = plot;
            if (!finished) begin
                start = 1'b0;
                if (changeAt >= 0 && plot && plotCount == changeAt) begin
                    values = vals2;
                    start  = 1'b1;
                end
                @(negedge clock);
                cyc++;
            end
        end
        start = 1'b0;
        if (!finished) timedOut = 1'b1;
        extra = 0;
        repeat (10) begin
            @(negedge clock);
            if (plot || done || busy) extra++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (10) begin
            @(negedge clock);
            nChecks++;
            if ({busy, done, plot, x, y, colour} !== 22'b0) begin
                nFails++;
                $display("[TB] FAIL reset_state: busy=%b done=%b plot=%b x=%0d y=%0d colour=%b, expected all zero",
                         busy, done, plot, x, y, colour);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_blank_frame();
        int bad;
        int badCol;
        int t, r, ex, ey;
        runFrame(64'h0, -1, 64'h0);
        nChecks++;
        if (timedOut || plotCount != 3600) begin
            nFails++;
            $display("[TB] FAIL blank_plot_count: got %0d timeout=%0d, expected 3600", plotCount, timedOut);
        end
        nChecks++;
        if (gapSeen || busyLow) begin
            nFails++;
            $display("[TB] FAIL blank_continuity: gap=%0d busyLow=%0d, expected 0 0", gapSeen, busyLow);
        end
        nChecks++;
        if (doneCycle != 3600 || doneCount != 1) begin
            nFails++;
            $display("[TB] FAIL blank_done_timing: doneCycle=%0d count=%0d, expected 3600 1", doneCycle, doneCount);
        end
        nChecks++;
        if (extra != 0) begin
            nFails++;
            $display("[TB] FAIL blank_after_done: %0d active cycles, expected 0", extra);
        end
        nChecks++;
        if (capX[0] !== 8'd57 || capY[0] !== 8'd27) begin
            nFails++;
            $display("[TB] FAIL first_pixel: (%0d,%0d), expected (57,27)", capX[0], capY[0]);
        end
        nChecks++;
        if (capX[225] !== 8'd74 || capY[225] !== 8'd27) begin
            nFails++;
            $display("[TB] FAIL tile1_first_pixel: (%0d,%0d), expected (74,27)", capX[225], capY[225]);
        end
        nChecks++;
        if (capX[3599] !== 8'd122 || capY[3599] !== 8'd92) begin
            nFails++;
            $display("[TB] FAIL last_pixel: (%0d,%0d), expected (122,92)", capX[3599], capY[3599]);
        end
        bad = 0;
        badCol = 0;
        for (int k = 0; k < NPIX; k++) begin
            t  = k / 225;
            r  = k % 225;
            ex = 57 + (t % 4) * 17 + (r % 15);
            ey = 27 + (t / 4) * 17 + (r / 15);
            if (capX[k] !== 8'(ex) || capY[k] !== 8'(ey)) bad++;
            if (capC[k] !== 3'b100) badCol++;
        end
        nChecks++;
        if (bad != 0) begin
            nFails++;
            $display("[TB] FAIL scan_order: %0d misplaced pixels, expected 0", bad);
        end
        nChecks++;
        if (badCol != 0) begin
            nFails++;
            $display("[TB] FAIL blank_colour: %0d pixels not 3'b100, expected 0", badCol);
        end
    endtask

    task automatic test_labels();
        // "2": box at px0=6, py0=5; row 0 = 111, row 1 = 001
        runFrame(64'h1000_0000_0000_0000, -1, 64'h0);
        nChecks++;
        if (capC[81] !== 3'b111 || capX[81] !== 8'd63 || capY[81] !== 8'd32) begin
            nFails++;
            $display("[TB] FAIL label2_lit: (%0d,%0d) colour=%b, expected (63,32) 111", capX[81], capY[81], capC[81]);
        end
        nChecks++;
        if (capC[0] !== 3'b100 || capC[96] !== 3'b100 || capC[98] !== 3'b111) begin
            nFails++;
            $display("[TB] FAIL label2_shape: c0=%b c96=%b c98=%b, expected 100 100 111", capC[0], capC[96], capC[98]);
        end
        // "4096": box at px0=0; "4" column 0 lit on rows 0..2 only, px3 is a gap
        runFrame(64'hC000_0000_0000_0000, -1, 64'h0);
        nChecks++;
        if (capC[75] !== 3'b111 || capX[75] !== 8'd57 || capC[120] !== 3'b100) begin
            nFails++;
            $display("[TB] FAIL label4096_left: x=%0d c75=%b c120=%b, expected x=57 111 100", capX[75], capC[75], capC[120]);
        end
        nChecks++;
        if (capC[78] !== 3'b100 || capC[79] !== 3'b111) begin
            nFails++;
            $display("[TB] FAIL label4096_gap: c78=%b c79=%b, expected 100 111", capC[78], capC[79]);
        end
        // "16": box at px0=4; "1" row 0 = 010, "6" row 3 = 101 starting at px8
        runFrame(64'h4000_0000_0000_0000, -1, 64'h0);
        nChecks++;
        if (capC[79] !== 3'b100 || capC[80] !== 3'b111 || capC[128] !== 3'b111 || capC[129] !== 3'b100) begin
            nFails++;
            $display("[TB] FAIL label16: c79=%b c80=%b c128=%b c129=%b, expected 100 111 111 100",
                     capC[79], capC[80], capC[128], capC[129]);
        end
    endtask

    task automatic test_err_and_snapshot();
        int errTile5;
        int errTotal;
        runFrame(64'h0000_0D00_0000_0000, 500, 64'hDDDD_DDDD_DDDD_DDDD);
        errTile5 = 0;
        errTotal = 0;
        for (int k = 0; k < NPIX; k++) begin
            if (capC[k] === 3'b110) begin
                errTotal++;
                if (k >= 1125 && k < 1350) errTile5++;
            end
        end
        nChecks++;
        if (errTile5 != 225 || errTotal != 225) begin
            nFails++;
            $display("[TB] FAIL err_tile: tile5=%0d total=%0d, expected 225 225", errTile5, errTotal);
        end
        nChecks++;
        if (plotCount != 3600 || doneCount != 1 || extra != 0) begin
            nFails++;
            $display("[TB] FAIL snapshot_no_restart: plots=%0d done=%0d extra=%0d, expected 3600 1 0",
                     plotCount, doneCount, extra);
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        int dones;
        bit hit;
        plotCount = 0;
        hit = 1'b0;
        cyc = 0;
        @(negedge clock);
        values = 64'h0;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        while (!hit && cyc < 5000) begin
            if (plot) plotCount++;
            if (plotCount == 1001) begin
                hit   = 1'b1;
                reset = 1'b1;
            end else begin
                @(negedge clock);
                cyc++;
            end
        end
        nChecks++;
        if (!hit) begin
            nFails++;
            $display("[TB] FAIL abort_reach: plots=%0d, expected to reach 1001", plotCount);
        end
        @(negedge clock);
        nChecks++;
        if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL abort_next_cycle: plot=%b done=%b busy=%b, expected 0 0 0", plot, done, busy);
        end
        reset = 1'b0;
        dones = 0;
        repeat (20) begin
            @(negedge clock);
            if (done || plot) dones++;
        end
        nChecks++;
        if (dones != 0) begin
            nFails++;
            $display("[TB] FAIL abort_no_done: %0d active cycles, expected 0", dones);
        end
        runFrame(64'h0, -1, 64'h0);
        nChecks++;
        if (plotCount != 3600 || capX[0] !== 8'd57 || capY[0] !== 8'd27 || doneCount != 1) begin
            nFails++;
            $display("[TB] FAIL abort_restart: plots=%0d first=(%0d,%0d) done=%0d, expected 3600 (57,27) 1",
                     plotCount, capX[0], capY[0], doneCount);
        end
    endtask

`ifdef DIRTY_REDRAW_EN
    task automatic test_dirty_redraw();
        int outside;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        runFrame(64'h0, -1, 64'h0);
        nChecks++;
        if (plotCount != 3600 || doneCount != 1) begin
            nFails++;
            $display("[TB] FAIL dirty_first_frame: plots=%0d done=%0d, expected 3600 1", plotCount, doneCount);
        end
        runFrame(64'h0001_0000_0000_0000, -1, 64'h0);
        outside = 0;
        for (int k = 0; k < 225 && k < plotCount; k++) begin
            if (capX[k] < 8'd108 || capX[k] > 8'd122 || capY[k] < 8'd27 || capY[k] > 8'd41) outside++;
        end
        nChecks++;
        if (plotCount != 225 || outside != 0 || doneCount != 1) begin
            nFails++;
            $display("[TB] FAIL dirty_one_tile: plots=%0d outside=%0d done=%0d, expected 225 0 1",
                     plotCount, outside, doneCount);
        end
        runFrame(64'h0001_0000_0000_0000, -1, 64'h0);
        nChecks++;
        if (plotCount != 0 || doneCycle != 0) begin
            nFails++;
            $display("[TB] FAIL dirty_unchanged: plots=%0d doneCycle=%0d, expected 0 0", plotCount, doneCycle);
        end
    endtask
`endif

    initial begin
        $display("[TB] grid_renderer bench starting");
        test_reset();
        test_blank_frame();
        test_labels();
        test_err_and_snapshot();
        test_reset_abort();
`ifdef DIRTY_REDRAW_EN
        test_dirty_redraw();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
